// File: rtl/cpu_pkg.sv
// Shared CPU register-file constants: default widths, the hard-wired zero
// register address and a helper that turns an address width into a depth.
package cpu_pkg;

    localparam int DATA_W_DEFAULT   = 32;
    localparam int ADDR_W_DEFAULT   = 5;
    localparam int NUM_REGS_DEFAULT = 2 ** ADDR_W_DEFAULT;

    // Architectural x0: reads as zero, swallows writes, never has a producer.
    localparam int REG_ZERO = 0;

    // Depth of a register file addressed by addr_w bits.
    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard. Issue marks a destination as having an
// in-flight producer; writeback clears it. A same-cycle issue beats a
// same-cycle writeback because the new instruction is the younger producer.
// busy_count is kept as a flop so it always equals the popcount of busy.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] busy_d,       busy_q;
    logic [ADDR_W:0]     busy_count_d, busy_count_q;

    // Decode issue/writeback into per-register set/clear masks and form the
    // next busy vector plus its population count.
    always_comb begin
        // NOTE: every variable gets a value before any conditional update, so
        // no path through this block can leave one unassigned and infer a latch.
        set_vec      = '0;
        clr_vec      = '0;
        busy_d       = busy_q;
        busy_count_d = '0;

        if (issue_valid) begin
            set_vec[issue_addr] = 1'b1;
        end

        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                clr_vec[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end

        // Set has priority over clear: a new producer was issued this cycle.
        busy_d = set_vec | (busy_q & ~clr_vec);

        // x0 never waits on anything, so an issue to it is simply discarded.
        if (ZERO_REG) begin
            busy_d[REG_ZERO] = 1'b0;
        end

        for (int r = 0; r < NUM_REGS; r++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[r]};
        end
    end

    // Busy bits and their count advance together on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = busy_count_q;

endmodule : reg_scoreboard

// File: rtl/multiport_register_file.sv
// Multi-ported integer register file: NUM_RD combinational read ports,
// NUM_WR clocked write ports, optional same-cycle write-to-read bypass and a
// busy scoreboard so decode can spot RAW hazards against in-flight writes.
module multiport_register_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [ADDR_W:0]          busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Scoreboard: busy vector, set/clear priority and busy_count.
    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .busy_count  (busy_count)
    );

    // Next-state of the storage array; ports are applied in ascending order
    // so the highest-index port wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] &&
                !(ZERO_REG && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO))) begin
                // NOTE: blocking assignments here are evaluated in order, so a
                // later port deliberately overwrites an earlier one; the flop
                // below is the only place that uses non-blocking assignment.
                mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Register array storage.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: this array is reset on purpose -- software relies on every
            // architectural register reading zero after reset. A plain data
            // RAM without that contract would be left unreset to map to SRAM.
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read ports: stored value, optionally overridden by a
    // same-cycle write, forced to zero for x0 and while reset is asserted.
    always_comb begin : read_mux
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rdata;
        logic              hit;

        rd_data = '0;
        rd_busy = '0;
        raddr   = '0;
        rdata   = '0;
        hit     = 1'b0;

        for (int k = 0; k < NUM_RD; k++) begin
            raddr = rd_addr[k*ADDR_W +: ADDR_W];
            rdata = mem_q[raddr];
            hit   = 1'b0;

            for (int j = 0; j < NUM_WR; j++) begin
                if (BYPASS && wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == raddr) begin
                    rdata = wr_data[j*DATA_W +: DATA_W];
                    hit   = 1'b1;
                end
            end

            if (ZERO_REG && raddr == ADDR_W'(REG_ZERO)) begin
                rdata = '0;
            end

            if (sys_rst_n) begin
                rd_data[k*DATA_W +: DATA_W] = rdata;
                // A bypassed writeback resolves the hazard in this same cycle.
                rd_busy[k] = busy[raddr] & ~hit;
            end
        end
    end

endmodule : multiport_register_file

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file. Instance "a" is the dual-write,
// bypassing configuration; instance "b" has one write port and no bypass.
module tb_multiport_register_file;

    logic        sys_clk;
    logic        sys_rst_n;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_issue_valid;
    logic [4:0]  a_issue_addr;
    logic [5:0]  a_busy_count;

    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [0:0]  b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_issue_valid;
    logic [4:0]  b_issue_addr;
    logic [5:0]  b_busy_count;

    int errors = 0;
    int checks = 0;

    multiport_register_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .rd_busy     (a_rd_busy),
        .wr_en       (a_wr_en),
        .wr_addr     (a_wr_addr),
        .wr_data     (a_wr_data),
        .issue_valid (a_issue_valid),
        .issue_addr  (a_issue_addr),
        .busy_count  (a_busy_count)
    );

    multiport_register_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .rd_busy     (b_rd_busy),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .issue_valid (b_issue_valid),
        .issue_addr  (b_issue_addr),
        .busy_count  (b_busy_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance to 1 ns after the next rising edge; inputs change here.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_wr_en       = '0;
        a_issue_valid = 1'b0;
        b_wr_en       = '0;
        b_issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n     = 1'b0;
        idle_inputs();
        a_rd_addr     = {5'd7, 5'd5};
        a_wr_addr     = '0;
        a_wr_data     = '0;
        a_issue_addr  = '0;
        b_rd_addr     = {5'd7, 5'd5};
        b_wr_addr     = '0;
        b_wr_data     = '0;
        b_issue_addr  = '0;
        #12;
        checks++;
        if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00 || a_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_in_reset: data=%h busy=%b count=%0d want 0/0/0",
                     a_rd_data, a_rd_busy, a_busy_count);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            a_rd_addr = {5'(31 - i), 5'(i)};
            b_rd_addr = {5'(31 - i), 5'(i)};
            #1;
            checks++;
            if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00 ||
                b_rd_data !== 64'd0 || b_rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL reset_read x%0d: a=%h/%b b=%h/%b want all 0",
                         i, a_rd_data, a_rd_busy, b_rd_data, b_rd_busy);
            end
        end
        checks++;
        if (a_busy_count !== 6'd0 || b_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_count: a=%0d b=%0d want 0", a_busy_count, b_busy_count);
        end
    endtask

    task automatic test_bypass();
        a_rd_addr = {5'd0, 5'd5};
        a_wr_en   = 2'b01;
        a_wr_addr = {5'd0, 5'd5};
        a_wr_data = {32'd0, 32'hDEADBEEF};
        b_rd_addr = {5'd0, 5'd5};
        b_wr_en   = 1'b1;
        b_wr_addr = 5'd5;
        b_wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h want deadbeef", a_rd_data[31:0]);
        end
        checks++;
        if (b_rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got %h want 00000000", b_rd_data[31:0]);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (a_rd_data[31:0] !== 32'hDEADBEEF || b_rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_next_cycle: a=%h b=%h want deadbeef",
                     a_rd_data[31:0], b_rd_data[31:0]);
        end
    endtask

    task automatic test_dual_write();
        a_rd_addr = {5'd5, 5'd7};
        a_wr_en   = 2'b11;
        a_wr_addr = {5'd7, 5'd7};
        a_wr_data = {32'h22, 32'h11};
        #1;
        checks++;
        if (a_rd_data[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL collide_bypass: got %h want 00000022", a_rd_data[31:0]);
        end
        step();
        a_wr_en = '0;
        #1;
        checks++;
        if (a_rd_data[31:0] !== 32'h22 || a_rd_data[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL collide_stored: x7=%h x5=%h want 22/deadbeef",
                     a_rd_data[31:0], a_rd_data[63:32]);
        end
        a_rd_addr = {5'd0, 5'd0};
        a_wr_en   = 2'b11;
        a_wr_addr = {5'd0, 5'd0};
        a_wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
        #1;
        checks++;
        if (a_rd_data !== 64'd0) begin
            errors++;
            $display("FAIL x0_bypass: got %h want 0", a_rd_data);
        end
        step();
        a_wr_en = '0;
        #1;
        checks++;
        if (a_rd_data !== 64'd0) begin
            errors++;
            $display("FAIL x0_stored: got %h want 0", a_rd_data);
        end
    endtask

    task automatic test_issue_writeback();
        a_rd_addr     = {5'd0, 5'd3};
        a_issue_valid = 1'b1;
        a_issue_addr  = 5'd3;
        #1;
        checks++;
        if (a_rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL issue_not_visible: got %b want 0", a_rd_busy[0]);
        end
        step();
        a_issue_valid = 1'b0;
        #1;
        checks++;
        if (a_rd_busy[0] !== 1'b1 || a_busy_count !== 6'd1) begin
            errors++;
            $display("FAIL issue_busy: busy=%b count=%0d want 1/1", a_rd_busy[0], a_busy_count);
        end
        a_wr_en   = 2'b01;
        a_wr_addr = {5'd0, 5'd3};
        a_wr_data = {32'd0, 32'h55};
        #1;
        checks++;
        if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h55 || a_busy_count !== 6'd1) begin
            errors++;
            $display("FAIL wb_bypass: busy=%b data=%h count=%0d want 0/55/1",
                     a_rd_busy[0], a_rd_data[31:0], a_busy_count);
        end
        step();
        a_wr_en = '0;
        #1;
        checks++;
        if (a_rd_busy[0] !== 1'b0 || a_busy_count !== 6'd0 || a_rd_data[31:0] !== 32'h55) begin
            errors++;
            $display("FAIL wb_done: busy=%b count=%0d data=%h want 0/0/55",
                     a_rd_busy[0], a_busy_count, a_rd_data[31:0]);
        end
        // Without bypass the hazard stays visible until the write lands.
        b_rd_addr     = {5'd0, 5'd3};
        b_issue_valid = 1'b1;
        b_issue_addr  = 5'd3;
        step();
        b_issue_valid = 1'b0;
        b_wr_en       = 1'b1;
        b_wr_addr     = 5'd3;
        b_wr_data     = 32'h66;
        #1;
        checks++;
        if (b_rd_busy[0] !== 1'b1 || b_rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_wb: busy=%b data=%h want 1/0", b_rd_busy[0], b_rd_data[31:0]);
        end
        step();
        b_wr_en = '0;
        #1;
        checks++;
        if (b_rd_busy[0] !== 1'b0 || b_rd_data[31:0] !== 32'h66 || b_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL nobypass_done: busy=%b data=%h count=%0d want 0/66/0",
                     b_rd_busy[0], b_rd_data[31:0], b_busy_count);
        end
    endtask

    task automatic test_set_over_clear();
        a_issue_valid = 1'b1;
        a_issue_addr  = 5'd9;
        a_wr_en       = 2'b01;
        a_wr_addr     = {5'd0, 5'd9};
        a_wr_data     = {32'd0, 32'h1};
        step();
        idle_inputs();
        a_rd_addr = {5'd0, 5'd9};
        #1;
        checks++;
        if (a_rd_busy[0] !== 1'b1 || a_rd_data[31:0] !== 32'h1 || a_busy_count !== 6'd1) begin
            errors++;
            $display("FAIL set_wins: busy=%b data=%h count=%0d want 1/1/1",
                     a_rd_busy[0], a_rd_data[31:0], a_busy_count);
        end
        a_issue_valid = 1'b1;
        a_issue_addr  = 5'd0;
        step();
        a_issue_valid = 1'b0;
        a_rd_addr     = {5'd9, 5'd0};
        #1;
        checks++;
        if (a_busy_count !== 6'd1 || a_rd_busy !== 2'b10) begin
            errors++;
            $display("FAIL issue_x0: count=%0d busy=%b want 1/10", a_busy_count, a_rd_busy);
        end
        a_wr_en   = 2'b10;
        a_wr_addr = {5'd9, 5'd0};
        a_wr_data = {32'h1, 32'd0};
        step();
        a_wr_en = '0;
        #1;
        checks++;
        if (a_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL clear_x9: count=%0d want 0", a_busy_count);
        end
    endtask

    task automatic test_busy_full();
        for (int i = 0; i < 32; i++) begin
            a_issue_valid = 1'b1;
            a_issue_addr  = 5'(i);
            step();
        end
        a_issue_valid = 1'b0;
        a_rd_addr     = {5'd31, 5'd0};
        #1;
        checks++;
        if (a_busy_count !== 6'd31 || a_rd_busy !== 2'b10) begin
            errors++;
            $display("FAIL busy_full: count=%0d busy=%b want 31/10", a_busy_count, a_rd_busy);
        end
        // Retire two registers per cycle: (1,2), (3,4) ... (31,0).
        for (int i = 1; i < 32; i += 2) begin
            a_wr_en   = 2'b11;
            a_wr_addr = {5'(i + 1), 5'(i)};
            a_wr_data = {32'(i + 1), 32'(i)};
            step();
            if (i == 15) begin
                a_wr_en = '0;
                #1;
                checks++;
                if (a_busy_count !== 6'd15) begin
                    errors++;
                    $display("FAIL busy_half: count=%0d want 15", a_busy_count);
                end
            end
        end
        a_wr_en = '0;
        #1;
        checks++;
        if (a_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL busy_drained: count=%0d want 0", a_busy_count);
        end
    endtask

    task automatic test_reset_mid_op();
        for (int i = 1; i <= 4; i++) begin
            a_issue_valid = 1'b1;
            a_issue_addr  = 5'(i);
            step();
        end
        a_issue_valid = 1'b0;
        a_rd_addr     = {5'd1, 5'd5};
        #1;
        checks++;
        if (a_busy_count !== 6'd4 || a_rd_busy !== 2'b10 || a_rd_data[31:0] !== 32'd5) begin
            errors++;
            $display("FAIL pre_reset: count=%0d busy=%b x5=%h want 4/10/5",
                     a_busy_count, a_rd_busy, a_rd_data[31:0]);
        end
        a_wr_en   = 2'b01;
        a_wr_addr = {5'd0, 5'd6};
        a_wr_data = {32'd0, 32'hAA};
        #1;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00 || a_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_immediate: data=%h busy=%b count=%0d want 0/0/0",
                     a_rd_data, a_rd_busy, a_busy_count);
        end
        a_wr_en = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        checks++;
        if (a_busy_count !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_count: count=%0d want 0", a_busy_count);
        end
        for (int i = 1; i <= 7; i++) begin
            a_rd_addr = {5'd6, 5'(i)};
            #1;
            checks++;
            if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_read x%0d: data=%h busy=%b want 0/0",
                         i, a_rd_data, a_rd_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_issue_writeback();
        test_set_over_clear();
        test_busy_full();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at 100000 ns, want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_multiport_register_file
